// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// One request may be outstanding; each channel uses a valid/ready handshake.
interface if_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic        imem_rsp_ready;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        output imem_rsp_ready,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        input  imem_rsp_ready,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: one outstanding imem fetch at a time, returned words
// land in a registered slot feeding IF/ID; honours stall and redirect.
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP_INSN = 32'h00000013
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [63:0]            redirect_pc,
    if_fetch_unit_if.master        imem,
    output logic [63:0]            pc_out,
    output logic [31:0]            instruction,
    output logic                   if_valid
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] pc_reg;
    logic        req_valid_q;
    logic        rsp_ready;
    logic        slot_load;
    logic        unused_pc_bits;

    assign imem.imem_req_valid = req_valid_q;
    assign imem.imem_req_addr  = pc_reg;
    assign imem.imem_rsp_ready = rsp_ready;
    assign unused_pc_bits      = ^redirect_pc[1:0];

    // A redirect in WAIT forces acceptance so a coincident response is drained
    // rather than left dangling behind a stalled slot.
    always_comb begin
        state_next = state;
        rsp_ready  = 1'b0;
        case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                if (imem.imem_req_ready)
                    state_next = redirect_valid ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                rsp_ready = redirect_valid || !if_valid || !stall;
                if (imem.imem_rsp_valid && rsp_ready)
                    state_next = S_REQ;
                else if (redirect_valid)
                    state_next = S_DROP;
            end
            S_DROP: begin
                rsp_ready = 1'b1;
                if (imem.imem_rsp_valid)
                    state_next = S_REQ;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign slot_load = (state == S_WAIT) && imem.imem_rsp_valid && rsp_ready && !redirect_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc_reg      <= RESET_PC;
            req_valid_q <= 1'b0;
            if_valid    <= 1'b0;
            pc_out      <= 64'h0;
            instruction <= NOP_INSN;
        end else begin
            state       <= state_next;
            req_valid_q <= (state_next == S_REQ);

            if (redirect_valid)
                pc_reg <= {redirect_pc[63:2], 2'b00};
            else if (slot_load)
                pc_reg <= pc_reg + 64'd4;

            // Slot: flush beats load, load beats consume; stall holds it bit-stable.
            if (redirect_valid) begin
                if_valid    <= 1'b0;
                instruction <= NOP_INSN;
            end else if (slot_load) begin
                if_valid    <= 1'b1;
                pc_out      <= pc_reg;
                instruction <= imem.imem_rsp_data;
            end else if (if_valid && !stall) begin
                if_valid    <= 1'b0;
                instruction <= NOP_INSN;
            end
        end
    end

endmodule
